// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the FIFO-buffered UART transmitter:
// shifter state encodings and default timing/size parameters.
package uart_tx_fifo_pkg;

    // 115,200 bps from a 50 MHz system clock
    localparam int DEFAULT_CLK_DIV    = 434;
    localparam int DEFAULT_FIFO_DEPTH = 8;
    localparam int BYTE_W             = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_byte_fifo.sv
// Byte FIFO with power-of-two depth; pointers wrap naturally at PTR_W bits.
// The caller guarantees rd_en only when not empty and wr_en only when not full or popping.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             sysclk,
    input  logic             sysreset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    always_ff @(posedge sysclk) begin
        if (!sysreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; clearing the pointers and count is enough
    // to make stale entries unreachable, and it keeps the array in RAM.
    always_ff @(posedge sysclk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    // On a simultaneous push/pop while full, the head is read before the edge
    // that overwrites the same slot.
    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO; the MCU pushes on a rising edge
// of load_data and polls tx_busy (FIFO full) before loading.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic              sysclk,
    input  logic              sysreset,
    input  logic [BYTE_W-1:0] parallel_in,
    input  logic              load_data,
    output logic              tx_line,
    output logic              tx_busy,
    output logic              tx_idle,
    output logic              overflow
);

    localparam int                BAUD_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

    tx_state_t         state;
    tx_state_t         state_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [BYTE_W-1:0] shift_reg;
    logic [BYTE_W-1:0] fifo_head;
    logic              load_q;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              baud_done;
    logic              tx_bit;
    logic              fifo_full;
    logic              fifo_empty;

    assign push_req  = load_data & ~load_q;
    assign push_ok   = push_req & (~fifo_full | pop);
    assign baud_done = (baud_cnt == BAUD_LAST);

    byte_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sysclk  (sysclk),
        .sysreset(sysreset),
        .wr_en   (push_ok),
        .wr_data (parallel_in),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // load_q resets high so a level already asserted at release is not a push.
    // NOTE: every register here uses <= so all of them see pre-edge values.
    always_ff @(posedge sysclk) begin
        if (!sysreset) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_line   <= 1'b1;
            load_q    <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            state   <= state_next;
            load_q  <= load_data;
            tx_line <= tx_bit;
            if (push_req && !push_ok)
                overflow <= 1'b1;
            if (state == ST_IDLE || baud_done)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;
            if (state == ST_START)
                bit_idx <= '0;
            else if (state == ST_DATA && baud_done)
                bit_idx <= bit_idx + 3'd1;
            if (pop)
                shift_reg <= fifo_head;
        end
    end

    // NOTE: state_next gets a default first so no path leaves it unassigned.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (!fifo_empty)                 state_next = ST_START;
            ST_START: if (baud_done)                   state_next = ST_DATA;
            ST_DATA:  if (baud_done && bit_idx == 3'd7) state_next = ST_STOP;
            ST_STOP:  if (baud_done)                   state_next = ST_IDLE;
            default:                                   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_bit = 1'b1;
        pop    = 1'b0;
        unique case (state)
            ST_IDLE:  pop    = ~fifo_empty;
            ST_START: tx_bit = 1'b0;
            ST_DATA:  tx_bit = shift_reg[bit_idx];
            ST_STOP:  tx_bit = 1'b1;
            default:  tx_bit = 1'b1;
        endcase
    end

    assign tx_busy = fifo_full;
    assign tx_idle = (state == ST_IDLE) && fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboarded bench: a small-divider instance for cycle-exact behaviour and
// a 434-divider instance decoded as a real 115,200 bps line.
module tb_uart_tx_fifo;

    logic       sysclk = 1'b0;
    logic       sysreset;
    logic [7:0] pin_a, pin_b;
    logic       load_a, load_b;
    logic       line_a, busy_a, idle_a, ovf_a;
    logic       line_b, busy_b, idle_b, ovf_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int frames_a = 0;
    int frames_b = 0;
    bit mon_en_a = 1'b1;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int         starts_a[$];
    int         starts_b[$];

    always #10 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    uart_tx_fifo #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut_a (
        .sysclk(sysclk), .sysreset(sysreset), .parallel_in(pin_a), .load_data(load_a),
        .tx_line(line_a), .tx_busy(busy_a), .tx_idle(idle_a), .overflow(ovf_a)
    );

    uart_tx_fifo #(.CLK_DIV(434), .FIFO_DEPTH(8)) dut_b (
        .sysclk(sysclk), .sysreset(sysreset), .parallel_in(pin_b), .load_data(load_b),
        .tx_line(line_b), .tx_busy(busy_b), .tx_idle(idle_b), .overflow(ovf_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic cur_line(input bit which);
        return which ? line_b : line_a;
    endfunction

    // Expected line level k cycles after the push-request cycle, div = 4.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k < 3)  return 1'b1;
        if (k < 7)  return 1'b0;
        if (k < 39) return b[(k - 7) / 4];
        return 1'b1;
    endfunction

    // Called at the negedge of the first start-bit cycle; samples mid-bit.
    task automatic decode(input bit which, input int div, output logic [7:0] b, output logic ok);
        ok = 1'b1;
        b  = '0;
        repeat (div / 2) @(negedge sysclk);
        if (cur_line(which) !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (div) @(negedge sysclk);
            b[i] = cur_line(which);
        end
        repeat (div) @(negedge sysclk);
        if (cur_line(which) !== 1'b1) ok = 1'b0;
    endtask

    initial begin : mon_a
        logic [7:0] b;
        logic       ok;
        forever begin
            @(negedge sysclk);
            if (line_a === 1'b0) begin
                starts_a.push_back(cyc);
                frames_a++;
                decode(1'b0, 4, b, ok);
                if (mon_en_a) begin
                    check("a_framing", ok, 1);
                    check("a_sb_nonempty", exp_a.size() != 0, 1);
                    if (exp_a.size() != 0) check("a_byte", b, exp_a.pop_front());
                end
            end
        end
    end

    initial begin : mon_b
        logic [7:0] b;
        logic       ok;
        forever begin
            @(negedge sysclk);
            if (line_b === 1'b0) begin
                starts_b.push_back(cyc);
                frames_b++;
                decode(1'b1, 434, b, ok);
                check("b_framing", ok, 1);
                check("b_sb_nonempty", exp_b.size() != 0, 1);
                if (exp_b.size() != 0) check("b_byte", b, exp_b.pop_front());
            end
        end
    end

    // Entered and left #1 after a rising edge.
    task automatic pulse(input bit which, input logic [7:0] b, input int hi, input int lo);
        if (which) begin pin_b = b; load_b = 1'b1; end
        else       begin pin_a = b; load_a = 1'b1; end
        repeat (hi) @(posedge sysclk);
        #1;
        if (which) load_b = 1'b0;
        else       load_a = 1'b0;
        repeat (lo) @(posedge sysclk);
        #1;
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic wait_drain(input bit which, input int budget);
        int n = 0;
        while (n < budget && (which ? (exp_b.size() != 0 || idle_b !== 1'b1)
                                    : (exp_a.size() != 0 || idle_a !== 1'b1))) begin
            @(posedge sysclk);
            #1;
            n++;
        end
        check(which ? "b_drain" : "a_drain", which ? exp_b.size() : exp_a.size(), 0);
        repeat (4) @(posedge sysclk);
        #1;
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] burst [6];
        int cp;
        int fa;
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        sysreset = 1'b0;
        load_a = 1'b1;       // held high through reset release
        pin_a  = 8'hEE;
        load_b = 1'b0;
        pin_b  = 8'h00;
        repeat (3) @(posedge sysclk);
        #1;
        check("rst_line", line_a, 1);
        check("rst_idle", idle_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_ovf",  ovf_a,  0);
        sysreset = 1'b1;
        repeat (6) @(posedge sysclk);
        #1;
        check("release_no_push_idle", idle_a, 1);
        check("release_no_push_frames", frames_a, 0);
        load_a = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;

        // Single 0x55 frame, cycle-exact against the push-request cycle
        pin_a = 8'h55;
        load_a = 1'b1;
        exp_a.push_back(8'h55);
        for (int k = 0; k < 43; k++) begin
            @(negedge sysclk);
            check($sformatf("f55_line_k%0d", k), line_a, frame_bit(8'h55, k));
        end
        check("f55_idle_after", idle_a, 1);
        @(posedge sysclk);
        #1;
        load_a = 1'b0;
        wait_drain(1'b0, 200);

        // Held level pushes once
        fa = frames_a;
        exp_a.push_back(8'hA3);
        pulse(1'b0, 8'hA3, 20, 1);
        wait_drain(1'b0, 300);
        check("hold_one_frame", frames_a - fa, 1);
        check("hold_no_ovf", ovf_a, 0);

        // Burst of six into a depth-4 FIFO: sixth is dropped
        starts_a.delete();
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_a.push_back(burst[i]);
            pulse(1'b0, burst[i], 2, 2);
            if (i == 4) begin
                check("burst_busy_full", busy_a, 1);
                check("burst_ovf_before", ovf_a, 0);
            end
        end
        check("burst_ovf_after", ovf_a, 1);
        check("burst_busy_after", busy_a, 1);
        wait_drain(1'b0, 600);
        check("burst_frames", starts_a.size(), 5);
        for (int i = 1; i < 5 && i < starts_a.size(); i++)
            check($sformatf("burst_spacing_%0d", i), starts_a[i] - starts_a[i-1], 41);

        sysreset = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;
        check("ovf_cleared", ovf_a, 0);
        sysreset = 1'b1;
        repeat (2) @(posedge sysclk);
        #1;

        // Push in the exact cycle the full FIFO pops (P+42)
        cp = cyc;
        for (int i = 0; i < 5; i++) begin
            exp_a.push_back(8'hC0 + 8'(i));
            pulse(1'b0, 8'hC0 + 8'(i), 1, 1);
        end
        check("pp_full", busy_a, 1);
        wait_cycle(cp + 42);
        check("pp_full_at_pop", busy_a, 1);
        exp_a.push_back(8'hC5);
        pulse(1'b0, 8'hC5, 1, 1);
        check("pp_no_ovf", ovf_a, 0);
        check("pp_still_full", busy_a, 1);
        wait_drain(1'b0, 800);
        check("pp_no_ovf_end", ovf_a, 0);

        // Reset during DATA bit 3 aborts the frame and discards the FIFO
        mon_en_a = 1'b0;
        cp = cyc;
        pulse(1'b0, 8'h00, 1, 1);
        pulse(1'b0, 8'h12, 1, 1);
        pulse(1'b0, 8'h34, 1, 1);
        wait_cycle(cp + 20);
        check("abort_bit3_low", line_a, 0);
        sysreset = 1'b0;
        @(posedge sysclk);
        #1;
        check("abort_line", line_a, 1);
        check("abort_idle", idle_a, 1);
        check("abort_busy", busy_a, 0);
        sysreset = 1'b1;
        repeat (60) @(posedge sysclk);
        #1;
        fa = frames_a;
        repeat (200) @(posedge sysclk);
        #1;
        check("abort_no_frames", frames_a, fa);
        check("abort_idle_end", idle_a, 1);
        mon_en_a = 1'b1;

        // "OK\n" at 115,200 bps
        foreach (burst[i]) burst[i] = 8'h00;
        exp_b.push_back(8'h4F);
        exp_b.push_back(8'h4B);
        exp_b.push_back(8'h0A);
        pulse(1'b1, 8'h4F, 2, 2);
        pulse(1'b1, 8'h4B, 2, 2);
        pulse(1'b1, 8'h0A, 2, 2);
        wait_drain(1'b1, 15000);
        check("b_frames", frames_b, 3);
        for (int i = 1; i < 3 && i < starts_b.size(); i++)
            check($sformatf("b_spacing_%0d", i), starts_b[i] - starts_b[i-1], 4341);
        check("b_ovf", ovf_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
